// File: rtl/mac_hash_table_lookup_pkg.sv
// Shared constants and types for the MAC hash-table lookup slice.
// Optional statistics feature is controlled by macro HASH_TABLE_STATS_EN.
package mac_hash_table_lookup_pkg;

  localparam int unsigned KEY_W  = 48;
  localparam int unsigned HASH_W = 32;

  // Entry header; the top wraps this with its parameterised data field.
  typedef struct packed {
    logic             valid;
    logic [KEY_W-1:0] key;
  } entry_tag_t;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

endpackage

// File: rtl/mac_hash_table_lookup_ram.sv
// Simple dual-port table RAM: synchronous read, write-first forwarding when
// the write and read addresses coincide in the same cycle.
module hash_table_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WIDTH  = 65
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (wr_en && (wr_addr == rd_addr)) rd_data <= wr_data;
    else                               rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mac_hash_table_lookup.sv
// Direct-mapped MAC hash table downstream of the hash pipeline; fixed latency
// HASH_LAT+3. Optional hit/miss counters under macro HASH_TABLE_STATS_EN.
module mac_hash_table_lookup
  import mac_hash_table_lookup_pkg::*;
#(
  parameter int unsigned HASH_LAT   = 7,
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
`ifdef HASH_TABLE_STATS_EN
  input  logic              stats_clear,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
`endif
  input  logic              key_in_valid,
  input  logic [KEY_W-1:0]  key_in,
  input  logic [HASH_W-1:0] hash_in,
  output logic              lkp_valid,
  output logic              lkp_hit,
  output logic [KEY_W-1:0]  lkp_key,
  output logic [DATA_W-1:0] lkp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic [HASH_W-1:0] wr_hash,
  input  logic [DATA_W-1:0] wr_data,
  output logic              init_done
);

  typedef struct packed {
    entry_tag_t        tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef logic [HASH_LAT-1:0]            valid_line_t;
  typedef logic [HASH_LAT-1:0][KEY_W-1:0] key_line_t;

  state_t                state, state_nx;
  logic [INDEX_BITS-1:0] clr_idx, clr_idx_nx;
  logic                  clr_wr;
  logic                  wr_fire;

  valid_line_t           dl_valid;
  key_line_t             dl_key;

  logic                  a_valid;
  logic [KEY_W-1:0]      a_key;
  logic [INDEX_BITS-1:0] a_idx;

  logic                  b_valid;
  logic                  b_clear;
  logic [KEY_W-1:0]      b_key;

  logic                  ram_wr_en;
  logic [INDEX_BITS-1:0] ram_wr_addr;
  entry_t                ram_wr_data;
  entry_t                ram_rd_data;
  logic                  hit;

  logic                  unused_hash_bits;
  assign unused_hash_bits = ^{hash_in[HASH_W-1:INDEX_BITS], wr_hash[HASH_W-1:INDEX_BITS]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_idx_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_idx_nx = clr_idx;
    clr_wr     = 1'b0;
    case (state)
      CLEAR: begin
        clr_wr     = 1'b1;
        clr_idx_nx = clr_idx + 1'b1;
        if (clr_idx == '1) state_nx = READY;
      end
      READY:   state_nx = READY;
      default: state_nx = CLEAR;
    endcase
  end

  assign init_done = (state == READY);
  assign wr_ready  = init_done;
  assign wr_fire   = wr_valid && init_done;

  // Clearing owns the write port; user writes are only accepted once READY.
  always_comb begin
    ram_wr_en   = clr_wr || wr_fire;
    ram_wr_addr = clr_wr ? clr_idx : wr_hash[INDEX_BITS-1:0];
    ram_wr_data = '0;
    if (!clr_wr) begin
      ram_wr_data.tag.valid = 1'b1;
      ram_wr_data.tag.key   = wr_key;
      ram_wr_data.data      = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    dl_key <= key_line_t'({dl_key, key_in});
    if (reset) dl_valid <= '0;
    else       dl_valid <= valid_line_t'({dl_valid, key_in_valid});
  end

  always_ff @(posedge clk) begin
    a_key <= dl_key[HASH_LAT-1];
    a_idx <= hash_in[INDEX_BITS-1:0];
    b_key <= a_key;
    if (reset) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      b_clear <= 1'b0;
    end else begin
      a_valid <= dl_valid[HASH_LAT-1];
      b_valid <= a_valid;
      b_clear <= (state == CLEAR);
    end
  end

  hash_table_ram #(
    .ADDR_W (INDEX_BITS),
    .WIDTH  ($bits(entry_t))
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data),
    .rd_addr (a_idx),
    .rd_data (ram_rd_data)
  );

  // Entries not yet cleared may hold stale contents, so reads during CLEAR miss.
  assign hit = b_valid && !b_clear && ram_rd_data.tag.valid && (ram_rd_data.tag.key == b_key);

  always_ff @(posedge clk) begin
    if (reset) begin
      lkp_valid <= 1'b0;
      lkp_hit   <= 1'b0;
      lkp_key   <= '0;
      lkp_data  <= '0;
    end else begin
      lkp_valid <= b_valid;
      lkp_hit   <= hit;
      lkp_key   <= b_key;
      lkp_data  <= hit ? ram_rd_data.data : '0;
    end
  end

`ifdef HASH_TABLE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (lkp_valid) begin
      if (lkp_hit) begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_hash_table_lookup.sv
// Self-checking bench for mac_hash_table_lookup: a table-level model resolves
// each lookup at its read cycle, a compare process checks every cycle.
module tb_mac_hash_table_lookup;

  localparam int N   = 256;
  localparam int HL  = 7;
  localparam int LAT = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_in_valid = 1'b0;
  logic [47:0] key_in = '0;
  logic [31:0] hash_in = '0;
  logic        lkp_valid, lkp_hit;
  logic [47:0] lkp_key;
  logic [15:0] lkp_data;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [47:0] wr_key = '0;
  logic [31:0] wr_hash = '0;
  logic [15:0] wr_data = '0;
  logic        init_done;
`ifdef HASH_TABLE_STATS_EN
  logic        stats_clear = 1'b0;
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  mac_hash_table_lookup #(
    .HASH_LAT   (7),
    .INDEX_BITS (8),
    .DATA_W     (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef HASH_TABLE_STATS_EN
    .stats_clear  (stats_clear),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
`endif
    .key_in_valid (key_in_valid),
    .key_in       (key_in),
    .hash_in      (hash_in),
    .lkp_valid    (lkp_valid),
    .lkp_hit      (lkp_hit),
    .lkp_key      (lkp_key),
    .lkp_data     (lkp_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_key       (wr_key),
    .wr_hash      (wr_hash),
    .wr_data      (wr_data),
    .init_done    (init_done)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = -1;

  bit          m_valid [N];
  logic [47:0] m_key   [N];
  logic [15:0] m_data  [N];
  logic [47:0] hist_k  [int];

  typedef struct {
    int          due;
    bit          hit;
    logic [47:0] key;
    logic [15:0] data;
  } exp_t;
  exp_t expq [$];

  bit          lk_v = 1'b0;
  logic [47:0] lk_key = '0;
  bit          w_v = 1'b0;
  logic [47:0] w_key = '0;
  logic [15:0] w_data = '0;

  function automatic logic [31:0] oaat(input logic [47:0] k);
    logic [31:0] h;
    h = '0;
    for (int i = 5; i >= 0; i--) begin
      h = h + {24'd0, k[i*8 +: 8]};
      h = h + (h << 10);
      h = h ^ (h >> 6);
    end
    h = h + (h << 3);
    h = h ^ (h >> 11);
    h = h + (h << 15);
    return h;
  endfunction

  function automatic int idx_of(input logic [47:0] k);
    logic [31:0] h;
    h = oaat(k);
    return int'(h[7:0]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // One clock cycle: drive inputs, update the model, advance.
  task automatic tick();
    exp_t        e;
    logic [47:0] k;
    int          i;
    key_in_valid = lk_v;
    key_in       = lk_key;
    if (hist_k.exists(cyc - HL)) hash_in = oaat(hist_k[cyc - HL]);
    else                         hash_in = $urandom();
    wr_valid = w_v;
    wr_key   = w_key;
    wr_hash  = oaat(w_key);
    wr_data  = w_data;
    if (lk_v) hist_k[cyc] = lk_key;
    if (w_v && cyc >= N) begin
      i = idx_of(w_key);
      m_valid[i] = 1'b1;
      m_key[i]   = w_key;
      m_data[i]  = w_data;
    end
    // The lookup issued HL+1 cycles ago reads the table this cycle.
    if (hist_k.exists(cyc - HL - 1)) begin
      k = hist_k[cyc - HL - 1];
      i = idx_of(k);
      e.due  = cyc + 2;
      e.key  = k;
      e.hit  = (cyc >= N) && m_valid[i] && (m_key[i] == k);
      e.data = e.hit ? m_data[i] : 16'h0;
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    lk_v = 1'b0;
    w_v  = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    cyc          = -1;
    lk_v         = 1'b0;
    w_v          = 1'b0;
    key_in_valid = 1'b0;
    wr_valid     = 1'b0;
    expq.delete();
    hist_k.delete();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    check("reset lkp_valid", 64'(lkp_valid), 64'(1'b0));
    check("reset lkp_hit",   64'(lkp_hit),   64'(1'b0));
    check("reset lkp_key",   64'(lkp_key),   64'(48'h0));
    check("reset lkp_data",  64'(lkp_data),  64'(16'h0));
    check("reset init_done", 64'(init_done), 64'(1'b0));
  endtask

  task automatic do_write(input logic [47:0] k, input logic [15:0] d);
    w_v = 1'b1; w_key = k; w_data = d;
    tick();
  endtask

  // Directed lookup with optional same-key write wr_at cycles after issue.
  task automatic lookup_at(input logic [47:0] k, input int wr_at, input logic [15:0] wd,
                           input bit exp_hit, input logic [15:0] exp_data, input string name);
    for (int d = 0; d < LAT; d++) begin
      if (d == 0)     begin lk_v = 1'b1; lk_key = k; end
      if (d == wr_at) begin w_v = 1'b1; w_key = k; w_data = wd; end
      tick();
    end
    check({name, " valid"}, 64'(lkp_valid), 64'(1'b1));
    check({name, " hit"},   64'(lkp_hit),   64'(exp_hit));
    check({name, " data"},  64'(lkp_data),  64'(exp_data));
    check({name, " key"},   64'(lkp_key),   64'(k));
  endtask

  function automatic logic [47:0] free_key(input logic [47:0] base);
    logic [47:0] k;
    k = base;
    for (int i = 0; i < 100000; i++) begin
      k = base + 48'(i);
      if (!m_valid[idx_of(k)]) break;
    end
    return k;
  endfunction

  always @(negedge clk) begin : cmp
    exp_t e;
    if (cyc >= 0) begin
      check("init_done", 64'(init_done), 64'(cyc >= N));
      check("wr_ready",  64'(wr_ready),  64'(cyc >= N));
      if (expq.size() > 0 && expq[0].due == cyc) begin
        e = expq.pop_front();
        check("stream lkp_valid", 64'(lkp_valid), 64'(1'b1));
        check("stream lkp_hit",   64'(lkp_hit),   64'(e.hit));
        check("stream lkp_key",   64'(lkp_key),   64'(e.key));
        check("stream lkp_data",  64'(lkp_data),  64'(e.data));
      end else begin
        check("idle lkp_valid", 64'(lkp_valid), 64'(1'b0));
      end
    end
  end

  initial begin
    logic [47:0] k1, ka, kb, kc, kf, kg;
    logic [47:0] pool [16];

    k1 = 48'h001122334455;
    do_reset();

    // Lookup during CLEAR still returns a (missing) result.
    lookup_at(k1, -1, 16'h0, 1'b0, 16'h0, "init lookup");
    while (cyc < N - 1) tick();
    check("init_done at 255", 64'(init_done), 64'(1'b0));
    tick();
    check("init_done at 256", 64'(init_done), 64'(1'b1));
    check("wr_ready at 256",  64'(wr_ready),  64'(1'b1));

    do_write(k1, 16'h0042);
    lookup_at(k1, -1, 16'h0, 1'b1, 16'h0042, "hit");

    ka = 48'hA0B0C0D0E0F0;
    kb = ka;
    for (int i = 1; i < 100000; i++) begin
      kb = ka + 48'(i);
      if (idx_of(kb) == idx_of(ka)) break;
    end
    do_write(ka, 16'h1111);
    do_write(kb, 16'h2222);
    lookup_at(ka, -1, 16'h0, 1'b0, 16'h0,    "collision A");
    lookup_at(kb, -1, 16'h0, 1'b1, 16'h2222, "collision B");

    kc = free_key(48'h5EED00000000);
    lookup_at(kc, -1, 16'h0, 1'b0, 16'h0, "unwritten");

    kf = free_key(48'h0F0F00000000);
    lookup_at(kf, 8, 16'hF00D, 1'b1, 16'hF00D, "forward T+8");
    kg = free_key(48'h0E0E00000000);
    lookup_at(kg, 9, 16'h0BAD, 1'b0, 16'h0, "late write T+9");

    for (int i = 0; i < 16; i++) pool[i] = 48'({$urandom(), $urandom()});
    for (int i = 0; i < 1000; i++) begin
      lk_v   = 1'b1;
      lk_key = ($urandom_range(0, 7) == 0) ? 48'({$urandom(), $urandom()})
                                           : pool[$urandom_range(0, 15)];
      if (i % 20 == 5) begin
        w_v = 1'b1; w_key = pool[$urandom_range(0, 15)]; w_data = 16'($urandom());
      end
      tick();
    end
    repeat (12) tick();

    // Reset with lookups in flight; the clear sequence must restart.
    for (int i = 0; i < 30; i++) begin
      lk_v = 1'b1; lk_key = pool[$urandom_range(0, 15)];
      tick();
    end
    do_reset();
    for (int i = 0; i < 300; i++) begin
      lk_v = 1'b1; lk_key = pool[$urandom_range(0, 15)];
      if (i % 10 == 3 && cyc >= N) begin
        w_v = 1'b1; w_key = pool[$urandom_range(0, 15)]; w_data = 16'($urandom());
      end
      tick();
    end
    repeat (12) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
